// File: rtl/fnn_pkg.sv
// Shared definitions for the feed-forward network datapath blocks.
// Holds the serializer state encoding so neighbouring layers agree on it.
package fnn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

endpackage

// File: rtl/layer_serializer.sv
// Collects one parallel result word per neuron and replays them as a gap-free
// serial burst (neuron 0 first) into the next layer's single input port.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no burst; waiting for every hold slot to be full
// SHIFT | emitting buffer element cnt on data_out with data_valid=1
module layer_serializer
    import fnn_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  neuron_out,
    input  logic [numNeurons-1:0]            neuron_valid,
    output logic [dataWidth-1:0]             data_out,
    output logic                             data_valid,
    output logic                             busy,
    output logic                             overrun
);

    localparam int CNT_W = $clog2(numNeurons);

    ser_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [numNeurons-1:0]  full_q, full_d;
    logic [dataWidth-1:0]   hold_q [numNeurons];
    logic [dataWidth-1:0]   hold_d [numNeurons];
    logic [dataWidth-1:0]   buf_q  [numNeurons];
    logic [dataWidth-1:0]   buf_d  [numNeurons];
    logic [dataWidth-1:0]   data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   overrun_q, overrun_d;

    logic                   cnt_last;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   transfer;

    assign cnt_last = (cnt_q == CNT_W'(numNeurons - 1));
    assign cnt_nxt  = cnt_q + CNT_W'(1);
    // A new set is only taken when the previous burst is on its last word,
    // which is what makes back-to-back bursts seamless.
    assign transfer = (&full_q) && ((state_q == IDLE) || cnt_last);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        full_d       = full_q;
        hold_d       = hold_q;
        buf_d        = buf_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        // Hold stage: a transfer frees every slot in the same cycle, so a
        // word arriving then is accepted rather than flagged as lost.
        for (int i = 0; i < numNeurons; i++) begin
            if (neuron_valid[i]) begin
                if (transfer || !full_q[i]) begin
                    hold_d[i] = neuron_out[i*dataWidth +: dataWidth];
                    full_d[i] = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (transfer) begin
                full_d[i] = 1'b0;
            end
        end

        if (transfer) begin
            buf_d        = hold_q;
            state_d      = SHIFT;
            cnt_d        = '0;
            data_out_d   = hold_q[0];
            data_valid_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_last) begin
                state_d      = IDLE;
                cnt_d        = '0;
                data_out_d   = '0;
                data_valid_d = 1'b0;
            end else begin
                cnt_d      = cnt_nxt;
                data_out_d = buf_q[cnt_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            full_q       <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < numNeurons; i++) begin
                hold_q[i] <= '0;
                buf_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            hold_q       <= hold_d;
            buf_q        <= buf_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q == SHIFT);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with four 16-bit neurons.
module tb_layer_serializer;

    localparam int N = 4;
    localparam int W = 16;

    logic             clk;
    logic             rst;
    logic [N*W-1:0]   neuron_out;
    logic [N-1:0]     neuron_valid;
    logic [W-1:0]     data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;

    int n_cmp;
    int n_err;

    layer_serializer #(.numNeurons(N), .dataWidth(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ok(input string tag);
        chk({tag, "_dv"},   32'(data_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy),       32'd0);
        chk({tag, "_do"},   32'(data_out),   32'd0);
    endtask

    // Checks the current cycle as word 0, then steps through words 1..3.
    task automatic burst_ok(input string tag, input logic [N*W-1:0] ws);
        for (int k = 0; k < N; k++) begin
            if (k != 0) step();
            chk({tag, "_dv"},   32'(data_valid), 32'd1);
            chk({tag, "_busy"}, 32'(busy),       32'd1);
            chk({tag, "_do"},   32'(data_out),   32'(ws[k*W +: W]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        neuron_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        neuron_out = '0;
        neuron_valid = '0;

        // Reset state, with neuron_valid held high to confirm it is ignored
        rst = 1'b1;
        neuron_valid = 4'b1111;
        neuron_out = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        step();
        step();
        rst = 1'b0;
        neuron_valid = '0;
        idle_ok("rst");
        chk("rst_ov", 32'(overrun), 32'd0);
        step();
        step();
        idle_ok("rst_ignore_nv");

        // All four together at edge 0, burst starts after edge 1
        neuron_out = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        neuron_valid = 4'b1111;
        step();
        neuron_valid = '0;
        idle_ok("sim_lat");
        step();
        burst_ok("sim", {16'h0044, 16'h0033, 16'h0022, 16'h0011});
        step();
        idle_ok("sim_end");
        chk("sim_ov", 32'(overrun), 32'd0);

        // Staggered arrivals at edges 0, 3, 5, 9
        for (int e = 0; e <= 9; e++) begin
            neuron_valid = '0;
            case (e)
                0: begin neuron_valid[0] = 1'b1; neuron_out[0*W +: W] = 16'h0101; end
                3: begin neuron_valid[1] = 1'b1; neuron_out[1*W +: W] = 16'h0202; end
                5: begin neuron_valid[2] = 1'b1; neuron_out[2*W +: W] = 16'h0303; end
                9: begin neuron_valid[3] = 1'b1; neuron_out[3*W +: W] = 16'h0404; end
                default: ;
            endcase
            step();
            neuron_valid = '0;
            chk("stag_wait_dv", 32'(data_valid), 32'd0);
        end
        step();
        burst_ok("stag", {16'h0404, 16'h0303, 16'h0202, 16'h0101});
        step();
        idle_ok("stag_end");

        // Back-to-back: second set lands during burst 1, 8 valid cycles
        neuron_out = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        neuron_valid = 4'b1111;
        step();
        neuron_valid = '0;
        step();
        chk("b2b_a0", 32'(data_out), 32'h1111);
        neuron_out = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
        neuron_valid = 4'b1111;
        step();
        neuron_valid = '0;
        chk("b2b_a1", 32'(data_out), 32'h2222);
        step();
        step();
        chk("b2b_a3", 32'(data_out), 32'h4444);
        step();
        burst_ok("b2b_b", {16'h8888, 16'h7777, 16'h6666, 16'h5555});
        step();
        idle_ok("b2b_end");
        chk("b2b_ov", 32'(overrun), 32'd0);

        // Valid for neuron 1 in the IDLE transfer cycle is kept for next burst
        neuron_out = {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1};
        neuron_valid = 4'b1111;
        step();
        neuron_out[1*W +: W] = 16'h5555;
        neuron_valid = 4'b0010;
        step();
        neuron_valid = '0;
        burst_ok("xfer_c", {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1});
        chk("xfer_ov", 32'(overrun), 32'd0);
        step();
        idle_ok("xfer_c_end");
        neuron_out = {16'h0E04, 16'h0E03, 16'h0000, 16'h0E01};
        neuron_valid = 4'b1101;
        step();
        neuron_valid = '0;
        step();
        burst_ok("xfer_d", {16'h0E04, 16'h0E03, 16'h5555, 16'h0E01});
        step();
        idle_ok("xfer_d_end");
        chk("xfer_d_ov", 32'(overrun), 32'd0);

        // Reset mid-burst at cnt=1 aborts the remaining words
        neuron_out = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        neuron_valid = 4'b1111;
        step();
        neuron_valid = '0;
        step();
        step();
        chk("abort_pre_do", 32'(data_out), 32'h0022);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_ok("abort");
        for (int c = 0; c < 4; c++) begin
            step();
            chk("abort_quiet_dv", 32'(data_valid), 32'd0);
        end

        // Reset clears a partially filled hold stage
        neuron_out = {16'h0000, 16'h0000, 16'h0000, 16'h0F01};
        neuron_valid = 4'b0001;
        step();
        neuron_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        neuron_out = {16'h0F04, 16'h0F03, 16'h0F02, 16'h0000};
        neuron_valid = 4'b1110;
        step();
        neuron_valid = '0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rstfull_dv", 32'(data_valid), 32'd0);
        end
        // Complete the set so the next test starts clean
        neuron_out[0*W +: W] = 16'h0F01;
        neuron_valid = 4'b0001;
        step();
        neuron_valid = '0;
        step();
        burst_ok("rstfull", {16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01});
        step();
        idle_ok("rstfull_end");

        // Overrun: neuron 2 fires twice before a transfer, first word wins
        neuron_out[2*W +: W] = 16'h0A0A;
        neuron_valid = 4'b0100;
        step();
        chk("ovr_first", 32'(overrun), 32'd0);
        neuron_out[2*W +: W] = 16'h0B0B;
        step();
        neuron_valid = '0;
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_nodv", 32'(data_valid), 32'd0);
        neuron_out = {16'h0904, 16'h0000, 16'h0902, 16'h0901};
        neuron_valid = 4'b1011;
        step();
        neuron_valid = '0;
        step();
        burst_ok("ovr", {16'h0904, 16'h0A0A, 16'h0902, 16'h0901});
        step();
        idle_ok("ovr_end");
        chk("ovr_sticky", 32'(overrun), 32'd1);
        step();
        chk("ovr_sticky2", 32'(overrun), 32'd1);
        do_reset();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
